// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - shared types, funct3 codes and store formatting for the store buffer
package store_pkg;

   localparam int SB_AW = 32;

   localparam logic [2:0] F3_SB = 3'b000;
   localparam logic [2:0] F3_SH = 3'b001;
   localparam logic [2:0] F3_SW = 3'b010;

   localparam logic [SB_AW-1:0] WORD_MASK = {{(SB_AW-2){1'b1}}, 2'b00};

   typedef struct packed {
      logic [SB_AW-1:0] addr;
      logic [31:0]      wdata;
      logic [3:0]       be;
   } sb_entry_t;

   typedef struct packed {
      sb_entry_t ent;
      logic      misaligned;
   } fmt_result_t;

   // Data is replicated across all lanes so memory only has to honour be.
   function automatic fmt_result_t fmt_store(input logic [2:0]       funct3,
                                             input logic [SB_AW-1:0] addr,
                                             input logic [31:0]      data);
      fmt_result_t r;
      r.ent.addr   = addr & WORD_MASK;
      r.ent.wdata  = data;
      r.ent.be     = 4'b0000;
      r.misaligned = 1'b0;
      case (funct3)
         F3_SB: begin
            r.ent.be    = 4'b0001 << addr[1:0];
            r.ent.wdata = {4{data[7:0]}};
         end
         F3_SH: begin
            r.ent.be     = addr[1] ? 4'b1100 : 4'b0011;
            r.ent.wdata  = {2{data[15:0]}};
            r.misaligned = addr[0];
         end
         F3_SW: begin
            r.ent.be     = 4'b1111;
            r.misaligned = (addr[1:0] != 2'b00);
         end
         default: r.misaligned = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/sb_fifo.sv
// rtl/sb_fifo.sv - entry storage with per-entry valid bits exposed for hazard lookup
module sb_fifo
   import store_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  sb_entry_t                push_entry,
   input  logic                     pop,
   output sb_entry_t                head,
   output sb_entry_t                entries [DEPTH],
   output logic [DEPTH-1:0]         entry_valid,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   sb_entry_t        mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];
   assign entries = mem;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         entry_valid <= '0;
      end else begin
         if (do_pop) begin
            rd_ptr              <= rd_ptr + 1'b1;
            entry_valid[rd_ptr] <= 1'b0;
         end
         if (do_push) begin
            wr_ptr              <= wr_ptr + 1'b1;
            entry_valid[wr_ptr] <= 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Payload needs no reset: it is only observed through valid bits and count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_entry;
   end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-store buffer: formats stores, queues them, flags load hazards
module store_buffer
   import store_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     st_valid,
   output logic                     st_ready,
   input  logic [AW-1:0]            st_addr,
   input  logic [31:0]              st_data,
   input  logic [2:0]               st_funct3,
   input  logic                     ld_chk_valid,
   input  logic [AW-1:0]            ld_chk_addr,
   output logic                     ld_hazard,
   output logic                     mem_valid,
   input  logic                     mem_ready,
   output logic [AW-1:0]            mem_addr,
   output logic [31:0]              mem_wdata,
   output logic [3:0]               mem_be,
   output logic                     misalign_err,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   logic [SB_AW-1:0] st_addr_ext;
   logic [SB_AW-1:0] ld_addr_ext;
   fmt_result_t      fmt;
   sb_entry_t        head;
   sb_entry_t        entries [DEPTH];
   logic [DEPTH-1:0] entry_valid;
   logic             full;
   logic             fifo_empty;
   logic             accept;
   logic             push;
   logic             pop;
   logic             hit;

   assign st_addr_ext = SB_AW'(st_addr);
   assign ld_addr_ext = SB_AW'(ld_chk_addr);
   assign fmt         = fmt_store(st_funct3, st_addr_ext, st_data);

   // Full always stalls, even when the head pops this cycle.
   assign st_ready = !full;
   assign accept   = st_valid && st_ready;
   assign push     = accept && !fmt.misaligned;
   assign pop      = !fifo_empty && mem_ready;

   sb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (push),
      .push_entry  (fmt.ent),
      .pop         (pop),
      .head        (head),
      .entries     (entries),
      .entry_valid (entry_valid),
      .full        (full),
      .empty       (fifo_empty),
      .count       (count)
   );

   assign empty     = fifo_empty;
   assign mem_valid = !fifo_empty;
   assign mem_addr  = AW'(head.addr);
   assign mem_wdata = head.wdata;
   assign mem_be    = head.be;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) misalign_err <= 1'b0;
      else        misalign_err <= accept && fmt.misaligned;
   end

   // Word-granular match; a popping entry is still valid until the edge.
   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_valid[i] && (((entries[i].addr ^ ld_addr_ext) & WORD_MASK) == '0))
            hit = 1'b1;
      end
      ld_hazard = ld_chk_valid && hit;
   end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed self-checking bench for store_buffer
module tb_store_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        st_valid;
   logic        st_ready;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [2:0]  st_funct3;
   logic        ld_chk_valid;
   logic [31:0] ld_chk_addr;
   logic        ld_hazard;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        misalign_err;
   logic        empty;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   store_buffer #(.DEPTH(4), .AW(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .st_valid     (st_valid),
      .st_ready     (st_ready),
      .st_addr      (st_addr),
      .st_data      (st_data),
      .st_funct3    (st_funct3),
      .ld_chk_valid (ld_chk_valid),
      .ld_chk_addr  (ld_chk_addr),
      .ld_hazard    (ld_hazard),
      .mem_valid    (mem_valid),
      .mem_ready    (mem_ready),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_be       (mem_be),
      .misalign_err (misalign_err),
      .empty        (empty),
      .count        (count)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
      st_valid  = 1'b1;
      st_addr   = a;
      st_data   = d;
      st_funct3 = f3;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_funct3 = '0;
      ld_chk_valid = 1'b1; ld_chk_addr = '0; mem_ready = 1'b0;
      #12;
      checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got %0b exp 0", mem_valid); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b exp 1", empty); end
      checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL reset_st_ready got %0b exp 1", st_ready); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
      checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign got %0b exp 0", misalign_err); end
      checks++; if (ld_hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard got %0b exp 0", ld_hazard); end
      ld_chk_valid = 1'b0;
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_sb();
      set_store(32'h1003, 32'h0000_00AB, 3'b000);
      #1;
      checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL sb_no_passthru got %0b exp 0", mem_valid); end
      step();
      st_valid = 1'b0;
      checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL sb_mem_valid got %0b exp 1", mem_valid); end
      checks++; if (mem_addr !== 32'h1000) begin errors++; $display("FAIL sb_addr got %h exp 00001000", mem_addr); end
      checks++; if (mem_be !== 4'b1000) begin errors++; $display("FAIL sb_be got %b exp 1000", mem_be); end
      checks++; if (mem_wdata[31:24] !== 8'hAB) begin errors++; $display("FAIL sb_wdata got %h exp AB", mem_wdata[31:24]); end
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL sb_drained got %0b exp 1", empty); end
   endtask

   task automatic test_drain_order();
      set_store(32'h2002, 32'h0000_1234, 3'b001);
      step();
      set_store(32'h3000, 32'hDEAD_BEEF, 3'b010);
      step();
      st_valid = 1'b0;
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL order_count got %0d exp 2", count); end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (mem_addr !== 32'h2000 || mem_be !== 4'b1100 || mem_wdata !== 32'h1234_1234) begin
            errors++; $display("FAIL order_head_stable cyc %0d got %h/%b/%h exp 00002000/1100/12341234", i, mem_addr, mem_be, mem_wdata);
         end
         step();
      end
      mem_ready = 1'b1;
      step();
      checks++;
      if (mem_addr !== 32'h3000 || mem_be !== 4'b1111 || mem_wdata !== 32'hDEAD_BEEF || count !== 3'd1) begin
         errors++; $display("FAIL order_second got %h/%b/%h cnt %0d exp 00003000/1111/deadbeef cnt 1", mem_addr, mem_be, mem_wdata, count);
      end
      step();
      mem_ready = 1'b0;
      checks++; if (empty !== 1'b1 || mem_valid !== 1'b0) begin errors++; $display("FAIL order_empty got empty %0b valid %0b exp 1 0", empty, mem_valid); end
   endtask

   task automatic test_full();
      for (int i = 0; i < 4; i++) begin
         set_store(32'h6000 + 32'(4*i), 32'h1111_0000 + 32'(i), 3'b010);
         step();
      end
      st_valid = 1'b0;
      checks++; if (count !== 3'd4 || st_ready !== 1'b0) begin errors++; $display("FAIL full_state got cnt %0d ready %0b exp 4 0", count, st_ready); end
      set_store(32'h9000, 32'hFFFF_FFFF, 3'b010);
      mem_ready = 1'b1;
      #1;
      checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL full_ready_with_pop got %0b exp 0", st_ready); end
      step();
      st_valid = 1'b0;
      checks++; if (count !== 3'd3 || mem_addr !== 32'h6004) begin errors++; $display("FAIL full_pop_only got cnt %0d head %h exp 3 00006004", count, mem_addr); end
      step();
      step();
      checks++; if (mem_addr !== 32'h600C || count !== 3'd1) begin errors++; $display("FAIL full_last got %h cnt %0d exp 0000600c 1", mem_addr, count); end
      step();
      mem_ready = 1'b0;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_no_stale_push got empty %0b exp 1", empty); end
   endtask

   task automatic test_misalign();
      logic [31:0] addrs [3];
      logic [2:0]  f3s   [3];
      addrs[0] = 32'h4002; f3s[0] = 3'b010;
      addrs[1] = 32'h4000; f3s[1] = 3'b011;
      addrs[2] = 32'h4001; f3s[2] = 3'b001;
      for (int i = 0; i < 3; i++) begin
         set_store(addrs[i], 32'hCAFE_F00D, f3s[i]);
         step();
         st_valid = 1'b0;
         checks++;
         if (misalign_err !== 1'b1 || count !== 3'd0 || mem_valid !== 1'b0) begin
            errors++; $display("FAIL misalign_%0d got err %0b cnt %0d valid %0b exp 1 0 0", i, misalign_err, count, mem_valid);
         end
         step();
         checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL misalign_pulse_%0d got %0b exp 0", i, misalign_err); end
      end
   endtask

   task automatic test_hazard();
      set_store(32'h5000, 32'h0BAD_F00D, 3'b010);
      ld_chk_valid = 1'b1; ld_chk_addr = 32'h5000;
      #1;
      checks++; if (ld_hazard !== 1'b0) begin errors++; $display("FAIL hazard_pushing got %0b exp 0", ld_hazard); end
      step();
      st_valid = 1'b0;
      ld_chk_addr = 32'h5003; #1;
      checks++; if (ld_hazard !== 1'b1) begin errors++; $display("FAIL hazard_hit got %0b exp 1", ld_hazard); end
      ld_chk_addr = 32'h5004; #1;
      checks++; if (ld_hazard !== 1'b0) begin errors++; $display("FAIL hazard_next_word got %0b exp 0", ld_hazard); end
      ld_chk_valid = 1'b0; ld_chk_addr = 32'h5003; #1;
      checks++; if (ld_hazard !== 1'b0) begin errors++; $display("FAIL hazard_no_probe got %0b exp 0", ld_hazard); end
      ld_chk_valid = 1'b1; mem_ready = 1'b1; #1;
      checks++; if (ld_hazard !== 1'b1) begin errors++; $display("FAIL hazard_popping got %0b exp 1", ld_hazard); end
      step();
      mem_ready = 1'b0;
      checks++; if (ld_hazard !== 1'b0) begin errors++; $display("FAIL hazard_after_pop got %0b exp 0", ld_hazard); end
      ld_chk_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      set_store(32'h7001, 32'h0000_005A, 3'b000);
      step();
      set_store(32'h7100, 32'h0000_BEEF, 3'b001);
      mem_ready = 1'b1;
      step();
      st_valid = 1'b0; mem_ready = 1'b0;
      checks++;
      if (count !== 3'd1 || mem_addr !== 32'h7100 || mem_be !== 4'b0011 || mem_wdata !== 32'hBEEF_BEEF) begin
         errors++; $display("FAIL b2b_head got cnt %0d %h/%b/%h exp 1 00007100/0011/beefbeef", count, mem_addr, mem_be, mem_wdata);
      end
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got %0b exp 1", empty); end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) begin
         set_store(32'h8000 + 32'(4*i), 32'h2222_0000 + 32'(i), 3'b010);
         step();
      end
      st_valid = 1'b0;
      checks++; if (mem_valid !== 1'b1 || count !== 3'd3) begin errors++; $display("FAIL arst_pre got valid %0b cnt %0d exp 1 3", mem_valid, count); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (mem_valid !== 1'b0 || empty !== 1'b1 || count !== 3'd0) begin
         errors++; $display("FAIL arst_immediate got valid %0b empty %0b cnt %0d exp 0 1 0", mem_valid, empty, count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      mem_ready = 1'b1;
      step();
      step();
      checks++; if (mem_valid !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL arst_no_stale got valid %0b empty %0b exp 0 1", mem_valid, empty); end
      mem_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_sb();
      test_drain_order();
      test_full();
      test_misalign();
      test_hazard();
      test_back_to_back();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-store buffer between the MEM-stage store-data formatter and the data memory write port.
- Accepts one store per cycle: byte address, raw 32-bit store data, funct3.
- Converts each store into a word-aligned address, lane-shifted write data and a 4-bit byte-enable, then queues it in a FIFO that drains to memory over a valid/ready handshake.
- Flags read-after-write hazards for loads that hit a still-pending store.

Parameters:
- DEPTH, 4, number of FIFO entries; must be a power of two, at least 2.
- AW, 32, byte-address width.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- st_valid  in  1  store request present this cycle.
- st_ready  out  1  buffer can accept a store (not full).
- st_addr  in  AW  byte address of the store.
- st_data  in  32  store data; low byte/half/word significant per funct3.
- st_funct3  in  3  000 = SB, 001 = SH, 010 = SW.
- ld_chk_valid  in  1  a load is probing the buffer this cycle.
- ld_chk_addr  in  AW  byte address of that load.
- ld_hazard  out  1  combinational; the load word matches a pending entry.
- mem_valid  out  1  head entry is presented to memory.
- mem_ready  in  1  memory accepts the head entry.
- mem_addr  out  AW  word-aligned address; bits [1:0] are always 0.
- mem_wdata  out  32  lane-aligned write data.
- mem_be  out  4  byte enables; bit i enables byte lane i.
- misalign_err  out  1  one-cycle pulse for a rejected store.
- empty  out  1  no pending entries.
- count  out  $clog2(DEPTH)+1  number of pending entries.

Behaviour:
- Reset (async assert, sync release): read/write pointers and count = 0; all entry valid bits = 0; misalign_err = 0. Outputs then read mem_valid = 0, ld_hazard = 0, empty = 1, st_ready = 1.
- Accept: a store is accepted when st_valid && st_ready. st_ready = (count != DEPTH), with no dependence on mem_ready. A full buffer always stalls, even if a pop occurs in the same cycle.
- Format, with L = st_addr[1:0]:
  - SB: be = 4'b0001 << L; wdata = {4{st_data[7:0]}}.
  - SH: be = L[1] ? 4'b1100 : 4'b0011; wdata = {2{st_data[15:0]}}.
  - SW: be = 4'b1111; wdata = st_data.
  - Unused lanes carry replicated data; memory must honour be.
- Misaligned or illegal store:
  - Covers SH with L[0]=1, SW with L != 0, and any funct3 outside {000, 001, 010}.
  - The store is consumed, not enqueued; misalign_err = 1 on the next cycle for one cycle; count is unchanged.
- Latency: a store accepted in cycle N appears at the head no earlier than cycle N+1. There is no combinational pass-through from st_* to mem_*.
- Drain:
  - mem_valid = !empty; mem_addr, mem_wdata and mem_be come from registered head-entry storage.
  - Pop on mem_valid && mem_ready.
  - mem_* must hold stable while mem_valid && !mem_ready.
- Simultaneous push and pop (not full): both happen and count is unchanged. When count = 1, the pushed entry becomes the head in the next cycle.
- Pointers: wrap modulo DEPTH with natural overflow of $clog2(DEPTH)-bit pointers. count is tracked separately, range 0..DEPTH.
- Hazard: ld_hazard = ld_chk_valid && OR over valid entries of (entry.addr[AW-1:2] == ld_chk_addr[AW-1:2]).
  - Word granularity; be is ignored.
  - An entry popping this cycle still counts; a store being pushed this cycle does not.
- Reset mid-operation: all pending stores are discarded and the handshake outputs drop immediately, asynchronously.

Decomposition:
- Shared package store_pkg:
  - funct3 constants F3_SB, F3_SH, F3_SW.
  - Packed struct sb_entry_t {addr, wdata, be}.
  - Function fmt_store(funct3, addr, data), returning the entry plus a misaligned flag.
- One sub-module, sb_fifo: parameterised DEPTH storage of sb_entry_t with per-entry valid bits exported for the hazard compare.
- Top level: formatting, error pulse, hazard OR-reduce.

Test Plan:
- After reset, SB addr 0x1003 data 0xAB -> next cycle mem_valid=1, mem_addr=0x1000, mem_be=4'b1000, mem_wdata[31:24]=0xAB.
- SH addr 0x2002 data 0x1234 and SW addr 0x3000 data 0xDEADBEEF with mem_ready=0 -> count=2, head holds 0x2000/be 1100/wdata[31:16]=0x1234 stable. Raise mem_ready -> drains in order, then empty=1.
- Push 4 stores with mem_ready=0 -> st_ready=0 with count=4. Same cycle: st_valid=1, mem_ready=1 -> exactly one pop, no push, count=3.
- SW addr 0x4002 -> misalign_err pulses 1 cycle, count unchanged, no memory request. funct3=3'b011 -> same response.
- Pending SW at 0x5000; ld_chk addr 0x5003 -> ld_hazard=1; ld_chk addr 0x5004 -> ld_hazard=0. After the pop completes, ld_chk 0x5003 -> ld_hazard=0.
- Assert rst_n low with 3 entries pending and mem_valid=1 -> mem_valid=0 and empty=1 immediately; after release, no stale request appears.
